ps2_interface: RTL and testbench
================================

# ps2_interface

Receive-only PS/2 host port that deserialises keyboard scan codes from the PS/2 clock/data lines into bytes for the system clock domain. It sits between the board's PS/2 connector and the LCD and seven-segment display logic. It reports each received byte with a one-cycle strobe and holds the most recent byte for display.

## Interface
- CLK_FREQ_HZ, 50_000_000, system clock frequency; informational only.
- FILTER_LEN, 8, consecutive equal samples required before the filtered PS/2 clock changes.
- TIMEOUT_CYCLES, 50_000, idle cycles (1 ms at 50 MHz) after which a partial frame is abandoned.

Ports:
- clock  in  1  system clock, single clock domain.
- resetn  in  1  asynchronous, active-low reset.
- ps2_clock  inout  1  PS/2 clock line; never driven, tied to high-Z.
- ps2_data  inout  1  PS/2 data line; never driven, tied to high-Z.
- ps2_key_data  out  8  received byte; valid only while ps2_key_pressed=1.
- ps2_key_pressed  out  1  one-cycle strobe per accepted byte.
- ps2_out  out  8  last accepted byte, held until the next one.

## Operation
- Both lines pass through a 2-flop synchroniser. The PS/2 clock then passes through a glitch filter: the filtered value takes the synchronised value after FILTER_LEN consecutive equal samples. Filter reset value is 1.
- A falling edge of the filtered clock samples the synchronised data bit.
- Frame format: start bit 0, 8 data bits LSB first, odd parity bit, stop bit 1.
- FSM states and transitions:
  - IDLE: an edge with data=0 goes to DATA. An edge with data=1 is ignored and stays in IDLE.
  - DATA: shifts 8 bits, then goes to PARITY.
  - PARITY: stores the parity bit, then goes to STOP.
  - STOP: data=1 with valid parity accepts the byte. Otherwise the byte is discarded. Either way, return to IDLE.
- Accept action: ps2_key_data and ps2_out take the byte, and ps2_key_pressed pulses high for one cycle.
- Timeout: in any non-IDLE state, TIMEOUT_CYCLES cycles without a filtered falling edge forces IDLE and discards the partial byte.
- Rejected frames leave ps2_out unchanged.
- Reset values: ps2_key_data=0x00, ps2_key_pressed=0, ps2_out=0x00, FSM=IDLE, shift register cleared, timeout counter cleared.
- Reset asserted mid-frame aborts the frame immediately with no strobe.

## Timing
- Latency from the raw ps2_clock falling edge of the stop bit to the ps2_key_pressed rising edge is exactly 2+FILTER_LEN+2 cycles (12 at the default).
- Strobe width is exactly one clock.
- Back-to-back frames separated by a single PS/2 bit period are both accepted.
- Low pulses on ps2_clock shorter than FILTER_LEN cycles produce no edge.

## Configuration
- PS2_PARITY_CHECK_EN:
  - Defined: a frame whose 9 bits (data plus parity) contain an even number of ones is discarded.
  - Undefined: the parity bit is sampled but ignored, and only start, stop and timeout errors reject a frame.

## Structure
- Shared package `ps2_pkg`:
  - FSM state enum (IDLE, DATA, PARITY, STOP).
  - Frame constants: DATA_BITS=8, START_VAL=0, STOP_VAL=1.
  - Default FILTER_LEN and TIMEOUT_CYCLES.
- One sub-module, `ps2_line_filter`: synchroniser, glitch filter and falling-edge detector. Outputs are the synchronised data and the edge strobe.
- The top level holds the FSM, shift register, parity, timeout counter and output registers.

## Test plan
- Valid frame 0x1C (parity 0): one strobe with ps2_key_data=0x1C, and ps2_out=0x1C afterwards. The strobe arrives 12 cycles after the stop-bit edge.
- Frames 0xF0 then 0x1C sent back to back: two strobes, values 0xF0 then 0x1C, and ps2_out ends at 0x1C.
- Frame 0x1C with parity bit 1:
  - With PS2_PARITY_CHECK_EN: no strobe, and ps2_out keeps its previous value.
  - Without the macro: strobe with 0x1C.
- Frame 0x29 with stop bit 0: no strobe. A following valid frame 0x29 gives one strobe.
- Five bits sent, then 2 ms idle, then a valid frame 0x5A: exactly one strobe with 0x5A.
- Two cases:
  - 3-cycle low glitch on ps2_clock: no bit is shifted.
  - resetn pulsed mid-frame: all outputs read 0x00/0, and the next valid frame 0x1C is received correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types and frame constants.
// Frame: start(0), 8 data bits LSB first, odd parity, stop(1).
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam int   DATA_BITS          = 8;
  localparam logic START_VAL          = 1'b0;
  localparam logic STOP_VAL           = 1'b1;
  localparam int   DEF_FILTER_LEN     = 8;
  localparam int   DEF_TIMEOUT_CYCLES = 50_000;

  // Odd parity holds when data plus parity carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioning: 2-flop synchronisers, clock glitch filter, registered falling-edge strobe.
// Latency raw clock fall -> fall strobe: 2 + FILTER_LEN + 1 cycles; data_bit is registered alongside fall.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clock,
  input  logic resetn,
  input  logic ps2_clk_raw,
  input  logic ps2_dat_raw,
  output logic data_bit,
  output logic fall
);

  localparam int             CW   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0]  LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          filt;
  logic          filt_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt     <= 1'b1;
      filt_q   <= 1'b1;
      cnt      <= '0;
      data_bit <= 1'b1;
      fall     <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_raw};
      dat_sync <= {dat_sync[0], ps2_dat_raw};
      // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples.
      if (clk_sync[1] == filt) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        filt <= clk_sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      filt_q   <= filt;
      fall     <= filt_q & ~filt;
      data_bit <= dat_sync[1];
    end
  end

endmodule

// File: rtl/ps2_interface.sv
// Receive-only PS/2 host port: frame FSM, shift register, parity, timeout and output registers.
// Optional odd-parity rejection under `PS2_PARITY_CHECK_EN; strobe 2+FILTER_LEN+2 cycles after stop-bit edge.
module ps2_interface
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 50_000_000,
  parameter int FILTER_LEN     = DEF_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clock,
  input  logic                 resetn,
  inout  wire                  ps2_clock,
  inout  wire                  ps2_data,
  output logic [DATA_BITS-1:0] ps2_key_data,
  output logic                 ps2_key_pressed,
  output logic [DATA_BITS-1:0] ps2_out
);

  localparam int                 TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]      TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam int                 BW    = $clog2(DATA_BITS);
  localparam logic [BW-1:0]      BLAST = BW'(DATA_BITS - 1);

  if (CLK_FREQ_HZ < 1 || FILTER_LEN < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("ps2_interface: CLK_FREQ_HZ >= 1, FILTER_LEN >= 2, TIMEOUT_CYCLES >= 2 required");
  end

  logic                 data_bit;
  logic                 fall;
  ps2_state_t           state;
  logic [DATA_BITS-1:0] shreg;
  logic [BW-1:0]        bit_cnt;
  logic                 parity_bit;
  logic [TW-1:0]        tcnt;
  logic                 frame_ok;

  // The host never pulls the lines low; both pins are only observed.
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clock       (clock),
    .resetn      (resetn),
    .ps2_clk_raw (ps2_clock),
    .ps2_dat_raw (ps2_data),
    .data_bit    (data_bit),
    .fall        (fall)
  );

`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok = (data_bit == STOP_VAL) && odd_parity_ok(shreg, parity_bit);
`else
  logic unused_parity;
  assign unused_parity = parity_bit;
  assign frame_ok      = (data_bit == STOP_VAL);
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      shreg           <= '0;
      bit_cnt         <= '0;
      parity_bit      <= 1'b0;
      tcnt            <= '0;
      ps2_key_data    <= '0;
      ps2_key_pressed <= 1'b0;
      ps2_out         <= '0;
    end else begin
      ps2_key_pressed <= 1'b0;
      if (state == IDLE || fall) tcnt <= '0;
      else                      tcnt <= tcnt + 1'b1;

      if (fall) begin
        case (state)
          IDLE: begin
            if (data_bit == START_VAL) begin
              state   <= DATA;
              bit_cnt <= '0;
              shreg   <= '0;
            end
          end
          DATA: begin
            shreg   <= {data_bit, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BLAST) state <= PARITY;
          end
          PARITY: begin
            parity_bit <= data_bit;
            state      <= STOP;
          end
          STOP: begin
            if (frame_ok) begin
              ps2_key_data    <= shreg;
              ps2_out         <= shreg;
              ps2_key_pressed <= 1'b1;
            end
            shreg <= '0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && tcnt == TLAST) begin
        // Sender went quiet mid-frame; drop the partial byte.
        state <= IDLE;
        shreg <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_interface.sv
// Scoreboard bench for ps2_interface: directed PS/2 frames, expected bytes queued, monitor compares each strobe.
module tb_ps2_interface;

  localparam int HALF = 40;
  localparam int TO   = 1000;

  logic       clock   = 1'b0;
  logic       resetn  = 1'b0;
  logic       clk_drv = 1'b1;
  logic       dat_drv = 1'b1;
  wire        ps2_clock_w;
  wire        ps2_data_w;
  logic [7:0] key_data;
  logic       pressed;
  logic [7:0] out;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_out = 8'h00;
  int         lat;

  assign ps2_clock_w = clk_drv;
  assign ps2_data_w  = dat_drv;

  always #5 clock = ~clock;

  ps2_interface #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
    .clock           (clock),
    .resetn          (resetn),
    .ps2_clock       (ps2_clock_w),
    .ps2_data        (ps2_data_w),
    .ps2_key_data    (key_data),
    .ps2_key_pressed (pressed),
    .ps2_out         (out)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d, input logic flip, input logic stop);
    return {stop, (~^d) ^ flip, d, 1'b0};
  endfunction

  // Sends the first n bits of a frame; latency counts cycles from the last clock fall to the strobe.
  task automatic send_bits(input logic [10:0] bits, input int n, output int latency);
    latency = -1;
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1 dat_drv = bits[i];
      repeat (HALF) @(posedge clock);
      #1 clk_drv = 1'b0;
      for (int k = 1; k <= HALF; k++) begin
        @(posedge clock);
        @(negedge clock);
        if (pressed && latency < 0 && i == n - 1) latency = k;
      end
      @(posedge clock); #1 clk_drv = 1'b1;
    end
    @(posedge clock); #1 dat_drv = 1'b1;
    repeat (HALF) @(posedge clock);
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_q.push_back(b);
    exp_out = b;
  endtask

  task automatic check_out(input string name);
    repeat (200) @(posedge clock);
    @(negedge clock);
    check(name, out, exp_out);
    check({name, "_pending"}, exp_q.size(), 0);
  endtask

  always @(negedge clock) begin : monitor
    logic [7:0] e;
    if (resetn && pressed) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe actual=0x%0h expected=none", key_data);
      end else begin
        e = exp_q.pop_front();
        check("strobe_data", key_data, e);
        check("strobe_out", out, e);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(posedge clock);
    @(negedge clock);
    check("reset_key_data", key_data, 8'h00);
    check("reset_pressed", pressed, 0);
    check("reset_out", out, 8'h00);
    @(posedge clock); #1 resetn = 1'b1;
    repeat (20) @(posedge clock);

    // Single valid frame, with stop-edge-to-strobe latency
    expect_byte(8'h1C);
    send_bits(frame(8'h1C, 1'b0, 1'b1), 11, lat);
    check("stop_to_strobe_latency", lat, 12);
    check_out("out_after_1c");

    // Back-to-back frames one bit period apart
    expect_byte(8'hF0);
    send_bits(frame(8'hF0, 1'b0, 1'b1), 11, lat);
    repeat (HALF) @(posedge clock);
    expect_byte(8'h1C);
    send_bits(frame(8'h1C, 1'b0, 1'b1), 11, lat);
    check_out("out_after_b2b");

    // Bad parity after a known-good 0xF0
    expect_byte(8'hF0);
    send_bits(frame(8'hF0, 1'b0, 1'b1), 11, lat);
`ifndef PS2_PARITY_CHECK_EN
    expect_byte(8'h1C);
`endif
    send_bits(frame(8'h1C, 1'b1, 1'b1), 11, lat);
    check_out("out_after_bad_parity");

    // Stop bit 0 rejected, then the same byte framed correctly
    send_bits(frame(8'h29, 1'b0, 1'b0), 11, lat);
    check_out("out_after_bad_stop");
    expect_byte(8'h29);
    send_bits(frame(8'h29, 1'b0, 1'b1), 11, lat);
    check_out("out_after_29");

    // Partial frame abandoned by timeout
    send_bits(frame(8'hA5, 1'b0, 1'b1), 5, lat);
    repeat (2 * TO) @(posedge clock);
    expect_byte(8'h5A);
    send_bits(frame(8'h5A, 1'b0, 1'b1), 11, lat);
    check_out("out_after_timeout");

    // 3-cycle clock glitch with data low must not start a frame
    @(posedge clock); #1 dat_drv = 1'b0;
    repeat (4) @(posedge clock);
    #1 clk_drv = 1'b0;
    repeat (3) @(posedge clock);
    #1 clk_drv = 1'b1;
    repeat (4) @(posedge clock);
    #1 dat_drv = 1'b1;
    repeat (20) @(posedge clock);
    expect_byte(8'h1C);
    send_bits(frame(8'h1C, 1'b0, 1'b1), 11, lat);
    check_out("out_after_glitch");

    // Reset mid-frame
    send_bits(frame(8'hA5, 1'b0, 1'b1), 5, lat);
    @(posedge clock); #1 resetn = 1'b0;
    exp_out = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("midreset_key_data", key_data, 8'h00);
    check("midreset_pressed", pressed, 0);
    check("midreset_out", out, 8'h00);
    @(posedge clock); #1 resetn = 1'b1;
    repeat (20) @(posedge clock);
    expect_byte(8'h1C);
    send_bits(frame(8'h1C, 1'b0, 1'b1), 11, lat);
    check_out("out_after_midreset");

    repeat (50) @(posedge clock);
    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
